uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
Drains the memory-mapped output FIFO written by the CPU through memmap at address 32'hFFFFFFFF. Serialises each word onto a UART line (8N1, LSB first). Owns the FIFO read port (data_out / empty_out / read_en_in) and is the only consumer of that FIFO. Frames are sent back-to-back while the FIFO is non-empty.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), word width of the FIFO and the number of data bits per frame
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range is 2 or more
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after a read strobe
fifo_empty  input  1  FIFO empty flag
fifo_read_enabled  output  1  one-cycle FIFO read strobe
tx_enable  input  1  permits starting a new frame; sampled only in IDLE
tx  output  1  UART serial line, idle high
busy  output  1  high from the FETCH state until the last stop bit completes

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, busy=0, fifo_read_enabled=0, baud counter=0, bit index=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately; tx returns to 1 asynchronously. The popped word is lost and is not re-read.
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles.
- IDLE: if tx_enable && !fifo_empty, go to FETCH. fifo_read_enabled is registered and is 1 during the FETCH cycle only.
- FETCH (1 cycle): the strobe is asserted. Next state is LOAD.
- LOAD (1 cycle): capture fifo_data_out into the shift register. The FIFO has 1-cycle registered read latency. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0]; shift right each bit period; DATA_WIDTH bits. Then go to PARITY if enabled, else STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
  - if tx_enable && !fifo_empty, go straight to FETCH (busy stays 1);
  - else go to IDLE.
- Frame latency: from IDLE with data available, the start bit begins 2 cycles after the IDLE decision edge.
- Back-to-back frame gap: 2 cycles of extra stop (FETCH+LOAD), with tx=1.
- fifo_read_enabled is never asserted when fifo_empty=1 at the decision edge. It is never asserted twice per frame.
- Simultaneous CPU write and drain: the empty flag is sampled at the decision edge only. A word arriving later waits for the next decision.
- tx_enable deasserted mid-frame: the current frame completes; no new fetch.
- tx is driven from a register and is glitch-free.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state inserted after DATA, one bit period. tx = XOR of all DATA_WIDTH data bits (even parity). Frame length becomes (1+DATA_WIDTH+1+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state exists; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - state enum typedef tx_state_t {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP};
  - localparam BAUD_CNT_W = $clog2(CLKS_PER_BIT);
  - idle line level constant UART_IDLE = 1'b1.
- One sub-module, uart_baud_tick: counter with clear input and a one-cycle tick output at CLKS_PER_BIT-1. It is reused by a future RX block.
- The FSM and shift register stay in uart_tx_drain.

Test Plan:
- Bench setup for all scenarios: CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1, real fifo instance (ADDR_WIDTH=4).
- Reset values: hold rst=0 with FIFO holding data -> tx=1, busy=0, fifo_read_enabled=0 throughout.
- Single word: push 44 (0x2C), tx_enable=1 -> exactly one read strobe; tx sequence per 4-cycle bit is 0,0,0,1,1,0,1,0,0,1. busy falls after 42 cycles counted from the strobe; fifo_empty=1.
- Back-to-back: push 0x55 then 0xA3 -> two frames with the second start bit exactly 2 cycles after the first stop bit ends. Data LSB-first matches 1,0,1,0,1,0,1,0 then 1,1,0,0,0,1,0,1.
- Flow control: FIFO empty or tx_enable=0 with data queued -> no strobe and tx stays 1 for 100 cycles. Raising tx_enable starts the frame 2 cycles later.
- Mid-frame reset: pull rst low during the 3rd data bit of 0xFF -> tx=1 within the same timestep. After release, the next queued word (0x0F) is sent intact.
- With UART_TX_PARITY_EN:
  - 0x2C (three 1s) -> parity bit 1 and frame length 44 cycles;
  - 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, baud counter sizing, line idle level.
// Also supplies the default `DATA_WIDTH (8) when the build does not define it.
// Optional parity is selected by the UART_TX_PARITY_EN macro in uart_tx_drain.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int BAUD_CNT_W       = $clog2(DEF_CLKS_PER_BIT);
  localparam logic UART_IDLE      = 1'b1;

  // Counter width for a given divide ratio; never narrower than one bit.
  function automatic int baud_cnt_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// Held at zero while clr is high so every bit period starts aligned.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Free-running divider that wraps on tick and parks at zero while cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains the CPU output FIFO onto an 8N1 (or 8E1) UART line, LSB first.
// Sequence per word: FETCH (read strobe) -> LOAD (capture) -> START -> DATA
// -> [PARITY] -> STOP, chaining straight into FETCH while words remain.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enabled,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  busy
);

  // Index covers both data bits and stop bits.
  localparam int IDX_W = $clog2(DATA_WIDTH + STOP_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  tick;
  logic                  cnt_clr;
  logic                  can_start;
`ifdef UART_TX_PARITY_EN
  logic                  par;
`endif

  // Timer only runs while a bit is actually on the line.
  assign cnt_clr   = (state == IDLE) || (state == FETCH) || (state == LOAD);
  assign shift_nxt = shift >> 1;
  assign can_start = tx_enable && !fifo_empty;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .tick (tick)
  );

  // Frame sequencer; tx, busy and the read strobe are all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      tx                <= UART_IDLE;
      busy              <= 1'b0;
      fifo_read_enabled <= 1'b0;
      bit_idx           <= '0;
      shift             <= '0;
`ifdef UART_TX_PARITY_EN
      par               <= 1'b0;
`endif
    end else begin
      fifo_read_enabled <= 1'b0;
      case (state)
        IDLE: begin
          if (can_start) begin
            state             <= FETCH;
            fifo_read_enabled <= 1'b1;
            busy              <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          // FIFO data is valid one cycle after the strobe.
          shift <= fifo_data_out;
`ifdef UART_TX_PARITY_EN
          par   <= ^fifo_data_out;
`endif
          state <= START;
          tx    <= 1'b0;
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par;
`else
              state   <= STOP;
              tx      <= UART_IDLE;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            tx      <= UART_IDLE;
            bit_idx <= '0;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              // Empty flag is sampled only here; later arrivals wait for IDLE.
              if (can_start) begin
                state             <= FETCH;
                fifo_read_enabled <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= UART_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1
// and a 16-entry behavioural FIFO with one-cycle registered read latency.
// Define UART_TX_PARITY_EN to exercise the parity build.
module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] fifo_data_out = '0;
  logic       fifo_empty;
  logic       fifo_read_enabled;
  logic       tx_enable = 1'b0;
  logic       tx;
  logic       busy;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] mem [16];
  logic [3:0] wptr = '0;
  logic [3:0] rptr = '0;
  int         count = 0;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  uart_tx_drain #(
    .DATA_WIDTH(8),
    .CLKS_PER_BIT(4),
    .STOP_BITS(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_data_out     (fifo_data_out),
    .fifo_empty        (fifo_empty),
    .fifo_read_enabled (fifo_read_enabled),
    .tx_enable         (tx_enable),
    .tx                (tx),
    .busy              (busy)
  );

  assign fifo_empty = (count == 0);

  // FIFO model: independent of the DUT reset so queued words survive it.
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + 1'b1;
    end
    if (fifo_read_enabled && count != 0) begin
      fifo_data_out <= mem[rptr];
      rptr          <= rptr + 1'b1;
    end
    count <= count + (wr_en ? 1 : 0) - ((fifo_read_enabled && count != 0) ? 1 : 0);
    if (fifo_read_enabled) strobes++;
  end

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_strobe(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_read_enabled === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no read strobe within 200 cycles", nm);
    end
  endtask

  // Entered at the FETCH-cycle negedge; leaves at the last stop-bit negedge.
  task automatic check_frame(input logic [7:0] d, input string nm);
    logic [10:0] b;
    logic        bad;
    logic        act;
`ifdef UART_TX_PARITY_EN
    b = {1'b1, ^d, d, 1'b0};
`else
    b = {1'b0, 1'b1, d, 1'b0};
`endif
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s fetch: tx=%b busy=%b, want tx=1 busy=1", nm, tx, busy);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL %s load: tx=%b, want 1", nm, tx);
    end
    for (int k = 0; k < FB; k++) begin
      bad = 1'b0;
      act = b[k];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (tx !== b[k]) begin
          bad = 1'b1;
          act = tx;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit %0d: tx=%b, want %b", nm, k, act, b[k]);
      end
    end
  endtask

  task automatic test_reset();
    push(8'h11);
    tx_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enabled !== 1'b0) begin
        errors++;
        $display("FAIL reset: tx=%b busy=%b rd=%b, want 1 0 0", tx, busy, fifo_read_enabled);
      end
    end
    // Drain the pre-loaded word so later tests start with an empty FIFO.
    rst = 1'b1;
    begin
      bit ok;
      wait_strobe("reset_drain", ok);
      if (ok) check_frame(8'h11, "reset_drain");
    end
    @(negedge clk);
    tx_enable = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int s0;
    s0 = strobes;
    tx_enable = 1'b1;
    push(8'h2C);
    wait_strobe("single", ok);
    if (ok) begin
      check_frame(8'h2C, "single");
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL single busy_last_stop: busy=%b, want 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
        errors++;
        $display("FAIL single busy_fall: busy=%b empty=%b, want 0 1", busy, fifo_empty);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (strobes != s0 + 1) begin
      errors++;
      $display("FAIL single strobe_count: got %0d, want %0d", strobes - s0, 1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    tx_enable = 1'b0;
    push(8'h55);
    push(8'hA3);
    tx_enable = 1'b1;
    wait_strobe("b2b_first", ok);
    if (ok) begin
      check_frame(8'h55, "b2b_first");
      @(negedge clk);
      checks++;
      if (fifo_read_enabled !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b gap: rd=%b busy=%b, want 1 1", fifo_read_enabled, busy);
      end
      check_frame(8'hA3, "b2b_second");
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
        errors++;
        $display("FAIL b2b end: busy=%b empty=%b, want 0 1", busy, fifo_empty);
      end
    end
  endtask

  task automatic test_flow_control();
    bit bad;
    int s0;
    s0 = strobes;
    tx_enable = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_read_enabled !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || strobes != s0) begin
      errors++;
      $display("FAIL flow empty_fifo: strobes=%0d line_ok=%b, want 0 1", strobes - s0, !bad);
    end
    tx_enable = 1'b0;
    push(8'h5A);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_read_enabled !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || strobes != s0) begin
      errors++;
      $display("FAIL flow tx_disabled: strobes=%0d line_ok=%b, want 0 1", strobes - s0, !bad);
    end
    tx_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_read_enabled !== 1'b1) begin
      errors++;
      $display("FAIL flow enable_latency: rd=%b, want 1", fifo_read_enabled);
    end else begin
      check_frame(8'h5A, "flow");
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit ok;
    int s0;
    s0 = strobes;
    tx_enable = 1'b0;
    push(8'hFF);
    push(8'h0F);
    tx_enable = 1'b1;
    wait_strobe("midrst", ok);
    if (ok) begin
      // LOAD, 4 start cycles, 8 cycles of bits 0-1, then into bit 2.
      repeat (1 + 4 + 8 + 2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enabled !== 1'b0) begin
        errors++;
        $display("FAIL midrst async: tx=%b busy=%b rd=%b, want 1 0 0", tx, busy, fifo_read_enabled);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_strobe("midrst_next", ok);
      if (ok) check_frame(8'h0F, "midrst_next");
      @(negedge clk);
      checks++;
      if (strobes != s0 + 2 || fifo_empty !== 1'b1) begin
        errors++;
        $display("FAIL midrst strobes: got %0d empty=%b, want 2 1", strobes - s0, fifo_empty);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    tx_enable = 1'b1;
    push(8'h03);
    wait_strobe("parity_03", ok);
    if (ok) begin
      check_frame(8'h03, "parity_03");
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL parity_03 busy_fall: busy=%b, want 0", busy);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flow_control();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
